// File: rtl/spm_sequencer.sv
// spm_sequencer: operand latch, serial multiplier feed and product collection for the SPM array.
// Latency: done pulses 2*WIDTH+2 cycles after an accepted start; back-to-back period 2*WIDTH+3.
// Backpressure: start is sampled only when idle; requests while busy are dropped, never queued.
// Build option: define SPM_SIGNED_EN for two's-complement operands (multiplier sign-extended).
module spm_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand_in,
  input  logic [WIDTH-1:0]     multiplier_in,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 spm_clr,
  output logic [WIDTH-1:0]     spm_multiplicand,
  output logic                 spm_x_bit,
  input  logic                 spm_p_bit
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(PW);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [PW-1:0]     coll_q, coll_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              clr_q, clr_d;
  logic              x_q, x_d;
  logic              ext_bit;
  logic [WIDTH-1:0]  b_shift;
  logic [PW-1:0]     coll_shift;
  logic              last_bit;

  // Fill bit for multiplier positions beyond WIDTH: the sign bit keeps repeating
  // in the signed build because the shift is arithmetic, otherwise zeros.
`ifdef SPM_SIGNED_EN
  assign ext_bit = b_q[WIDTH-1];
`else
  assign ext_bit = 1'b0;
`endif

  assign b_shift    = {ext_bit, b_q[WIDTH-1:1]};
  assign coll_shift = {spm_p_bit, coll_q[PW-1:1]};
  assign last_bit   = (cnt_q == CW'(PW - 1));

  // Next-state and datapath: x_bit is registered one edge ahead so the array sees
  // a glitch-free B[k] for the whole of RUN cycle k.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    coll_d  = coll_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    clr_d   = 1'b0;
    x_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = multiplicand_in;
          b_d     = multiplier_in;
          clr_d   = 1'b1;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        cnt_d   = '0;
        coll_d  = '0;
        x_d     = b_q[0];
        b_d     = b_shift;
        state_d = RUN;
      end
      RUN: begin
        coll_d = coll_shift;
        if (last_bit) begin
          cnt_d   = '0;
          prod_d  = coll_shift;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          x_d   = b_q[0];
          b_d   = b_shift;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      coll_q  <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      clr_q   <= 1'b0;
      x_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      coll_q  <= coll_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      clr_q   <= clr_d;
      x_q     <= x_d;
    end
  end

  assign busy             = (state_q != IDLE);
  assign done             = (state_q == DONE);
  assign product          = prod_q;
  assign spm_clr          = clr_q;
  assign spm_multiplicand = a_q;
  assign spm_x_bit        = x_q;

endmodule

// File: tb/tb_spm_sequencer.sv
// tb_spm_sequencer: directed bench for spm_sequencer with a behavioural serial array model.
// Latency: n/a.
// Backpressure: n/a.
module tb_spm_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  a_in = 8'd0;
  logic [7:0]  b_in = 8'd0;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic        spm_clr;
  logic [7:0]  spm_mc;
  logic        spm_x_bit;
  logic        spm_p_bit;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Array model: serial-parallel accumulate, product bit k = LSB of running sum.
  bit                 force_mode = 1'b0;
  int                 force_k    = 0;
  int                 k_tb       = 100;
  logic signed [31:0] acc = 32'sd0;
  logic signed [31:0] aext;
  logic signed [31:0] sum;

  spm_sequencer #(.WIDTH(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .multiplicand_in  (a_in),
    .multiplier_in    (b_in),
    .busy             (busy),
    .done             (done),
    .product          (product),
    .spm_clr          (spm_clr),
    .spm_multiplicand (spm_mc),
    .spm_x_bit        (spm_x_bit),
    .spm_p_bit        (spm_p_bit)
  );

  always #5 clk = ~clk;

  always_comb begin
`ifdef SPM_SIGNED_EN
    aext = {{24{spm_mc[7]}}, spm_mc};
`else
    aext = {24'd0, spm_mc};
`endif
    sum = acc + (spm_x_bit ? aext : 32'sd0);
  end

  assign spm_p_bit = force_mode ? (k_tb == force_k) : sum[0];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (spm_clr) k_tb <= 0;
    else if (k_tb < 100) k_tb <= k_tb + 1;
    if (spm_clr) acc <= 32'sd0;
    else acc <= sum >>> 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 100) $display("FAIL launch_idle: busy=%b want 0", busy);
    else n_pass++;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (done !== 1'b1 && n < 100);
    n_checks++;
    if (done !== 1'b1) $display("FAIL done_timeout: done=%b want 1 within 100 cycles", done);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_checks++; if (spm_clr !== 1'b0) $display("FAIL reset_clr: got %b want 0", spm_clr); else n_pass++;
    n_checks++; if (spm_x_bit !== 1'b0) $display("FAIL reset_x: got %b want 0", spm_x_bit); else n_pass++;
    n_checks++; if (product !== 16'h0000) $display("FAIL reset_product: got %h want 0000", product); else n_pass++;
    n_checks++; if (spm_mc !== 8'h00) $display("FAIL reset_mc: got %h want 00", spm_mc); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL post_reset_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_bit_order();
    force_mode = 1'b1;
    force_k    = 0;
    launch(8'd5, 8'd9);
    @(negedge clk);
    n_checks++; if (spm_clr !== 1'b1) $display("FAIL clr_in_clear: got %b want 1", spm_clr); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL busy_in_clear: got %b want 1", busy); else n_pass++;
    n_checks++; if (spm_x_bit !== 1'b0) $display("FAIL x_in_clear: got %b want 0", spm_x_bit); else n_pass++;
    n_checks++; if (spm_mc !== 8'd5) $display("FAIL mc_latched: got %0d want 5", spm_mc); else n_pass++;
    @(negedge clk);
    n_checks++; if (spm_clr !== 1'b0) $display("FAIL clr_first_run: got %b want 0", spm_clr); else n_pass++;
    wait_done();
    n_checks++; if (product !== 16'h0001) $display("FAIL bit_order_k0: got %h want 0001", product); else n_pass++;
    force_k = 15;
    launch(8'd5, 8'd9);
    wait_done();
    n_checks++; if (product !== 16'h8000) $display("FAIL bit_order_k15: got %h want 8000", product); else n_pass++;
    force_mode = 1'b0;
  endtask

  task automatic test_product(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
    logic ext;
    logic xe;
`ifdef SPM_SIGNED_EN
    ext = b[7];
`else
    ext = 1'b0;
`endif
    launch(a, b);
    @(negedge clk);
    n_checks++; if (spm_clr !== 1'b1) $display("FAIL prod_clr: got %b want 1", spm_clr); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL prod_done_clear: got %b want 0", done); else n_pass++;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      xe = (k < 8) ? b[k] : ext;
      n_checks++;
      if (spm_x_bit !== xe) $display("FAIL x_bit_k%0d: got %b want %b", k, spm_x_bit, xe);
      else n_pass++;
      n_checks++;
      if (done !== 1'b0) $display("FAIL early_done_k%0d: got %b want 0", k, done);
      else n_pass++;
    end
    @(negedge clk);
    n_checks++; if (done !== 1'b1) $display("FAIL done_latency18: got %b want 1", done); else n_pass++;
    n_checks++; if (product !== exp) $display("FAIL product_%h_%h: got %h want %h", a, b, product, exp); else n_pass++;
    @(negedge clk);
    n_checks++; if (done !== 1'b0) $display("FAIL done_one_cycle: got %b want 0", done); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL busy_after_done: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_operand_change();
    launch(8'd11, 8'd13);
    repeat (5) @(negedge clk);
    a_in = 8'hFF;
    b_in = 8'hFF;
    @(negedge clk);
    n_checks++; if (spm_mc !== 8'd11) $display("FAIL mc_held: got %0d want 11", spm_mc); else n_pass++;
    wait_done();
    n_checks++; if (product !== 16'd143) $display("FAIL operand_change: got %0d want 143", product); else n_pass++;
  endtask

  task automatic test_start_during_run();
    int ndone;
    logic [15:0] pdone;
    ndone = 0;
    pdone = 16'h0;
    launch(8'd7, 8'd9);
    repeat (6) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    n_checks++; if (product !== 16'd143) $display("FAIL product_held_in_run: got %0d want 143", product); else n_pass++;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        pdone = product;
      end
    end
    n_checks++; if (ndone !== 1) $display("FAIL start_ignored_dones: got %0d want 1", ndone); else n_pass++;
    n_checks++; if (pdone !== 16'd63) $display("FAIL start_ignored_product: got %0d want 63", pdone); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL start_not_queued: busy=%b want 0", busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int t1;
    int t2;
    int n;
    t1 = -1;
    t2 = -1;
    n  = 0;
    @(negedge clk);
    a_in  = 8'd3;
    b_in  = 8'd4;
    start = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (t1 < 0) t1 = cyc;
        else if (t2 < 0) t2 = cyc;
      end
    end
    start = 1'b0;
    n_checks++;
    if (t1 < 0 || t2 < 0 || (t2 - t1) != 19) $display("FAIL back_to_back_period: got %0d want 19", t2 - t1);
    else n_pass++;
    while (busy !== 1'b0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    n_checks++; if (product !== 16'd12) $display("FAIL back_to_back_product: got %0d want 12", product); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int ndone;
    ndone = 0;
    launch(8'd6, 8'd7);
    @(negedge clk);
    repeat (6) @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (product !== 16'h0000) $display("FAIL midrst_product: got %h want 0000", product); else n_pass++;
    n_checks++; if (spm_x_bit !== 1'b0) $display("FAIL midrst_x: got %b want 0", spm_x_bit); else n_pass++;
    n_checks++; if (spm_mc !== 8'h00) $display("FAIL midrst_mc: got %h want 00", spm_mc); else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    n_checks++; if (ndone !== 0) $display("FAIL midrst_no_done: got %0d pulses want 0", ndone); else n_pass++;
    launch(8'd6, 8'd7);
    wait_done();
    n_checks++; if (product !== 16'd42) $display("FAIL midrst_recover: got %0d want 42", product); else n_pass++;
  endtask

  task automatic test_hold();
    @(negedge clk);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n_checks++; if (product !== 16'd42) $display("FAIL hold_product_c%0d: got %0d want 42", i, product); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL hold_done_c%0d: got %b want 0", i, done); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL hold_busy_c%0d: got %b want 0", i, busy); else n_pass++;
      n_checks++; if (spm_x_bit !== 1'b0) $display("FAIL hold_x_c%0d: got %b want 0", i, spm_x_bit); else n_pass++;
      n_checks++; if (spm_mc !== 8'd6) $display("FAIL hold_mc_c%0d: got %0d want 6", i, spm_mc); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_bit_order();
`ifdef SPM_SIGNED_EN
    test_product(8'hFD, 8'h05, 16'hFFF1);
    test_product(8'h80, 8'h80, 16'h4000);
`else
    test_product(8'd200, 8'd150, 16'd30000);
    test_product(8'd255, 8'd255, 16'd65025);
`endif
    test_operand_change();
    test_start_during_run();
    test_back_to_back();
    test_reset_mid_run();
    test_hold();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spm_sequencer.md
Name: spm_sequencer

Overview:
- Control and collection stage wrapped around the serial-parallel multiplier array.
- Accepts a parallel operand pair on a start handshake and clears the array.
- Streams the multiplier into the array one bit per clock, LSB first.
- Collects the serial product bits the array emits into a 2*WIDTH parallel product, then pulses done.

Parameters:
- WIDTH, 8, operand width in bits. Product is 2*WIDTH bits. Bit counter is clog2(2*WIDTH) bits wide.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  request a new multiplication; sampled only in IDLE.
- multiplicand_in  input  WIDTH  operand A; latched on accepted start.
- multiplier_in  input  WIDTH  operand B; latched on accepted start.
- busy  output  1  high from accepted start through the DONE cycle.
- done  output  1  one-cycle pulse when product is updated.
- product  output  2*WIDTH  last completed product; held until the next completion.
- spm_clr  output  1  synchronous clear to array cells; high for exactly one cycle (CLEAR).
- spm_multiplicand  output  WIDTH  latched operand A, held stable for the whole operation.
- spm_x_bit  output  1  serial multiplier bit to the array.
- spm_p_bit  input  1  serial product bit from the array, valid in the same cycle as spm_x_bit.

Behaviour:
- FSM states: IDLE, CLEAR, RUN, DONE.
- Reset (rst=0, asynchronous):
  - state=IDLE, busy=0, done=0, spm_clr=0, spm_x_bit=0.
  - product=0, spm_multiplicand=0, internal operand and shift registers=0, counter=0.
  - Reset mid-operation aborts the operation; no done pulse is produced.
- IDLE:
  - busy=0.
  - start=1 at a clock edge: latch both operands, go to CLEAR.
- CLEAR, one cycle:
  - spm_clr=1, busy=1, spm_x_bit=0, counter=0.
  - Go to RUN.
- RUN, exactly 2*WIDTH cycles, counter k = 0 .. 2*WIDTH-1:
  - spm_x_bit = B[k] for k < WIDTH.
  - For k >= WIDTH, spm_x_bit is the extension bit (see Optional Feature).
  - At each edge: shift spm_p_bit into the MSB of the collect register (shift right), k+1.
  - After 2*WIDTH samples, the collect register holds the product bit 0 at the LSB.
  - At the edge with k = 2*WIDTH-1: go to DONE.
- DONE, one cycle:
  - product <= collect register.
  - done=1, busy=1.
  - Go to IDLE.
- Timing:
  - start accepted at edge E0; done is high during cycle E0+2*WIDTH+1 to E0+2*WIDTH+2 (2*WIDTH+2 cycles after acceptance).
  - New product is visible in the same cycle as done.
- start while busy: ignored, not queued.
- start held high continuously: a new operation begins the cycle after DONE returns to IDLE. The back-to-back period is 2*WIDTH+3 cycles.
- Operand inputs may change freely after acceptance; only the latched copies are used.
- spm_clr is a registered output. No glitches on spm_clr or spm_x_bit.

Optional Feature:
- Macro: SPM_SIGNED_EN.
- Defined:
  - Extension bits in RUN (k >= WIDTH) equal B[WIDTH-1], i.e. two's-complement sign extension.
  - product is interpreted as a signed 2*WIDTH result.
- Undefined:
  - Extension bits are 0.
  - Operands and product are unsigned.
- All other timing is identical in both builds.

Test Plan:
- Reset mid-RUN: assert rst=0 at k=5 -> busy=0, product=0, no done pulse; the next start completes normally.
- Bit ordering: bench drives spm_p_bit = 1 only at k=0 -> product=16'h0001; 1 only at k=15 -> product=16'h8000; spm_clr high exactly one cycle before the first RUN cycle.
- Unsigned product: with a behavioural array model, A=8'd200, B=8'd150, macro undefined -> product=16'd30000; done exactly 18 cycles after acceptance; spm_x_bit for k=8..15 is 0.
- Signed product: with SPM_SIGNED_EN and the signed array model, A=8'hFD (-3), B=8'h05 -> product=16'hFFF1 (-15). A=8'h80, B=8'h80 -> product=16'h4000.
- Handshake:
  - start pulsed during RUN -> ignored; a single done pulse; product unchanged until that done.
  - start held high -> done pulses exactly 19 cycles apart.
  - Operands changed mid-RUN -> result uses the latched values.
- Hold behaviour: after completion, with start=0 for 50 cycles -> product stable, done=0, busy=0, spm_x_bit=0, spm_multiplicand unchanged.
